// File: rtl/arb_pkg.sv
// Shared constants and helpers for the round-robin arbiter.
// Contents:
//   ARB_DEF_NUM_REQ - default requester count
//   ARB_MAX_REQ     - widest request vector onehot2idx can encode
//   onehot2idx      - binary index of the set bit of a one-hot vector (0 for all-zero)
package arb_pkg;

   localparam int unsigned ARB_DEF_NUM_REQ = 4;
   localparam int unsigned ARB_MAX_REQ     = 32;
   localparam int unsigned ARB_MAX_IDX_W   = 5;

   // OR of the indices of all set bits; exact for one-hot or all-zero input
   function automatic logic [ARB_MAX_IDX_W-1:0] onehot2idx(input logic [ARB_MAX_REQ-1:0] oh);
      logic [ARB_MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
         if (((oh >> i) & ARB_MAX_REQ'(1)) != '0) begin
            idx = idx | ARB_MAX_IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority picker.
// Priority descends from i_ptr: i_ptr, i_ptr-1, ..., 0, NUM_REQ-1, ..., i_ptr+1.
// Ports:
//   i_req    [NUM_REQ-1:0] request vector
//   i_ptr    [IDX_W-1:0]   index currently holding highest priority
//   o_gnt_c  [NUM_REQ-1:0] one-hot winner (all-zero when no request)
//   o_idx_c  [IDX_W-1:0]   binary index of the winner (0 when no request)
//   o_any_c                at least one request present
module rr_prio_pick import arb_pkg::*; #(
   parameter  int unsigned NUM_REQ = ARB_DEF_NUM_REQ,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt_c,
   output logic [IDX_W-1:0]   o_idx_c,
   output logic               o_any_c
);

   logic [IDX_W:0]           w_sh;       // rotate amount that lands i_ptr on the top bit
   logic [IDX_W:0]           w_sh_back;  // complementary amount to undo the rotation
   logic [2*NUM_REQ-1:0]     w_req_dbl;
   logic [NUM_REQ-1:0]       w_rot;
   logic [NUM_REQ-1:0]       w_pick_rot;
   logic [2*NUM_REQ-1:0]     w_pick_dbl;

   assign w_sh      = {1'b0, i_ptr} + (IDX_W+1)'(1);
   assign w_sh_back = (IDX_W+1)'(NUM_REQ) - w_sh;

   // Rotate right so that bit i_ptr becomes bit NUM_REQ-1
   assign w_req_dbl = {i_req, i_req};
   assign w_rot     = NUM_REQ'(w_req_dbl >> w_sh);

   // Fixed priority: highest set bit of the rotated vector wins
   for (genvar j = 0; j < NUM_REQ; j++) begin : g_pick
      assign w_pick_rot[j] = w_rot[j] & ~(|(w_rot >> (j + 1)));
   end

   // Rotate the winner back into requester numbering
   assign w_pick_dbl = {w_pick_rot, w_pick_rot};
   assign o_gnt_c    = NUM_REQ'(w_pick_dbl >> w_sh_back);
   assign o_idx_c    = IDX_W'(onehot2idx(ARB_MAX_REQ'(o_gnt_c)));
   assign o_any_c    = |i_req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant; the winner drops to lowest
// priority after each grant. Out of reset the highest index has priority.
// Optional feature macro: RR_ARB_HOLD_EN - owner keeps the grant for up to MAX_HOLD
// consecutive cycles while it still requests.
// Ports:
//   i_clock               rising-edge clock
//   i_reset_n             asynchronous active-low reset
//   i_en                  arbitration enable; 0 gives no grant at the next edge
//   i_req   [NUM_REQ-1:0] request vector, bit i = requester i
//   o_gnt   [NUM_REQ-1:0] registered one-hot grant or all-zero
//   o_gnt_valid           registered, equals |o_gnt
//   o_gnt_idx [IDX_W-1:0] registered index of the granted bit, 0 when no grant
module rr_arbiter import arb_pkg::*; #(
   parameter  int unsigned NUM_REQ  = ARB_DEF_NUM_REQ,
   parameter  int unsigned MAX_HOLD = 4,
   localparam int unsigned IDX_W    = $clog2(NUM_REQ)
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_en,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic               o_gnt_valid,
   output logic [IDX_W-1:0]   o_gnt_idx
);

   // Elaboration-time parameter checks
   if (NUM_REQ < 2) begin : g_chk_num_req
      $error("rr_arbiter: NUM_REQ must be >= 2");
   end
   if (NUM_REQ > ARB_MAX_REQ) begin : g_chk_num_req_max
      $error("rr_arbiter: NUM_REQ exceeds ARB_MAX_REQ");
   end
   if (MAX_HOLD < 1) begin : g_chk_max_hold
      $error("rr_arbiter: MAX_HOLD must be >= 1");
   end

   logic [NUM_REQ-1:0] r_gnt;
   logic               r_valid;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   r_ptr;

   logic [NUM_REQ-1:0] w_pick;
   logic [IDX_W-1:0]   w_pick_idx;
   logic               w_any;
   logic               w_hold;

   logic [NUM_REQ-1:0] w_nxt_gnt;
   logic               w_nxt_valid;
   logic [IDX_W-1:0]   w_nxt_idx;
   logic [IDX_W-1:0]   w_nxt_ptr;

   rr_prio_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_gnt_c (w_pick),
      .o_idx_c (w_pick_idx),
      .o_any_c (w_any)
   );

`ifdef RR_ARB_HOLD_EN
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_nxt_hold_cnt;

   // Current owner still requesting and under its hold budget
   assign w_hold = i_en && r_valid && ((i_req & r_gnt) != '0) &&
                   (r_hold_cnt < HOLD_W'(MAX_HOLD));

   // Hold counter: counts consecutive cycles of the current ownership
   always_comb begin
      w_nxt_hold_cnt = '0;
      if (w_hold) begin
         w_nxt_hold_cnt = r_hold_cnt + HOLD_W'(1);
      end else if (i_en && w_any) begin
         w_nxt_hold_cnt = HOLD_W'(1);
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_hold_cnt <= '0;
      end else begin
         r_hold_cnt <= w_nxt_hold_cnt;
      end
   end
`else
   assign w_hold = 1'b0;
`endif

   // Next grant and pointer; a new winner becomes lowest priority
   always_comb begin
      w_nxt_gnt   = '0;
      w_nxt_valid = 1'b0;
      w_nxt_idx   = '0;
      w_nxt_ptr   = r_ptr;
      if (w_hold) begin
         w_nxt_gnt   = r_gnt;
         w_nxt_valid = 1'b1;
         w_nxt_idx   = r_idx;
      end else if (i_en && w_any) begin
         w_nxt_gnt   = w_pick;
         w_nxt_valid = 1'b1;
         w_nxt_idx   = w_pick_idx;
         w_nxt_ptr   = (w_pick_idx == '0) ? IDX_W'(NUM_REQ - 1) : (w_pick_idx - IDX_W'(1));
      end
   end

   // Grant and pointer registers
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_gnt   <= '0;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_ptr   <= IDX_W'(NUM_REQ - 1);
      end else begin
         r_gnt   <= w_nxt_gnt;
         r_valid <= w_nxt_valid;
         r_idx   <= w_nxt_idx;
         r_ptr   <= w_nxt_ptr;
      end
   end

   assign o_gnt       = r_gnt;
   assign o_gnt_valid = r_valid;
   assign o_gnt_idx   = r_idx;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (NUM_REQ=4, MAX_HOLD=2).
// Hold-mode scenarios run when RR_ARB_HOLD_EN is defined; rotation and enable
// scenarios run in the default build.
module tb_rr_arbiter;

   localparam int unsigned NUM_REQ  = 4;
   localparam int unsigned MAX_HOLD = 2;
   localparam int unsigned IDX_W    = 2;

   logic               clk;
   logic               rst_n;
   logic               en;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic               gnt_valid;
   logic [IDX_W-1:0]   gnt_idx;

   int n_checks;
   int n_fail;

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .i_clock     (clk),
      .i_reset_n   (rst_n),
      .i_en        (en),
      .i_req       (req),
      .o_gnt       (gnt),
      .o_gnt_valid (gnt_valid),
      .o_gnt_idx   (gnt_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_gnt(input string tag, input logic [NUM_REQ-1:0] exp_gnt);
      logic [IDX_W-1:0] exp_idx;
      exp_idx = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (exp_gnt[i]) exp_idx = IDX_W'(i);
      end
      check_eq({tag, ".gnt"},   32'(gnt),       32'(exp_gnt));
      check_eq({tag, ".valid"}, 32'(gnt_valid), 32'(|exp_gnt));
      check_eq({tag, ".idx"},   32'(gnt_idx),   32'(exp_idx));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      req   = '0;
      step();
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      logic [NUM_REQ-1:0] exp_rot [5];
      logic [NUM_REQ-1:0] exp_sparse [3];
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      req      = '0;

      // 1: reset state and first grant
      step();
      check_gnt("reset", 4'b0000);
      do_reset();
      en  = 1'b1;
      req = 4'b1111;
      step();
      check_gnt("first", 4'b1000);

`ifndef RR_ARB_HOLD_EN
      // 2: rotation with all requesting, then sparse requests
      exp_rot = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
      for (int i = 0; i < 5; i++) begin
         step();
         check_gnt($sformatf("rot%0d", i), exp_rot[i]);
      end
      // ptr is now 1 (last winner 2)
      req = 4'b0101;
      exp_sparse = '{4'b0001, 4'b0100, 4'b0001};
      for (int i = 0; i < 3; i++) begin
         step();
         check_gnt($sformatf("sparse%0d", i), exp_sparse[i]);
      end

      // 3: enable low suppresses grants and keeps the pointer (last winner 0)
      req = 4'b1111;
      en  = 1'b0;
      step();
      check_gnt("en_off0", 4'b0000);
      step();
      check_gnt("en_off1", 4'b0000);
      en = 1'b1;
      step();
      check_gnt("en_resume", 4'b1000);
      step();
      check_gnt("en_resume2", 4'b0100);
      req = 4'b0000;
      step();
      check_gnt("no_req", 4'b0000);
      req = 4'b1111;
      step();
      check_gnt("after_idle", 4'b0010);
`else
      // 4: hold with two requesters
      do_reset();
      en  = 1'b1;
      req = 4'b1010;
      exp_rot = '{4'b1000, 4'b1000, 4'b0010, 4'b0010, 4'b1000};
      for (int i = 0; i < 5; i++) begin
         step();
         check_gnt($sformatf("hold%0d", i), exp_rot[i]);
      end
      // owner drops during its first hold cycle
      do_reset();
      en  = 1'b1;
      req = 4'b1010;
      step();
      check_gnt("drop0", 4'b1000);
      req = 4'b0010;
      step();
      check_gnt("drop1", 4'b0010);

      // 5: sole requester re-granted with hold counter cycling
      do_reset();
      en  = 1'b1;
      req = 4'b0001;
      exp_sparse = '{4'b0001, 4'b0001, 4'b0001};
      for (int i = 0; i < 5; i++) begin
         step();
         check_gnt($sformatf("sole%0d", i), 4'b0001);
         check_eq($sformatf("sole%0d.cnt", i), 32'(dut.r_hold_cnt), (i % 2 == 0) ? 32'd1 : 32'd2);
      end
`endif

      // 6: async reset mid-grant
      do_reset();
      en  = 1'b1;
      req = 4'b0100;
      step();
      check_gnt("pre_arst", 4'b0100);
      #2;
      rst_n = 1'b0;
      #1;
      check_gnt("arst", 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b1111;
      step();
      check_gnt("post_arst", 4'b1000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
